// File: rtl/handshake_const_sink_pkg.sv
// Shared definitions for the handshake constant sink: state encoding and a width helper.
package handshake_sink_pkg;

   localparam logic ST_ACCEPT = 1'b0;
   localparam logic ST_REPORT = 1'b1;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/handshake_const_sink_if.sv
// Valid/ready channels of the constant sink: token input and report output.
interface handshake_const_sink_if #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned COUNT_WIDTH = 16
);

   logic [DATA_WIDTH-1:0]  ins;
   logic                   ins_valid;
   logic                   ins_ready;
   logic [COUNT_WIDTH-1:0] outs;
   logic                   outs_valid;
   logic                   outs_ready;

   // Producer of tokens / consumer of reports.
   modport master (
      output ins,
      output ins_valid,
      input  ins_ready,
      input  outs,
      input  outs_valid,
      output outs_ready
   );

   // The sink itself.
   modport slave (
      input  ins,
      input  ins_valid,
      output ins_ready,
      output outs,
      output outs_valid,
      input  outs_ready
   );

endinterface

// File: rtl/handshake_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module handshake_sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] cnt_d;
   logic [WIDTH-1:0] cnt_q;

   // Next count: clear, else increment unless already at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   // Count register, asynchronously cleared.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign q = cnt_q;

endmodule

// File: rtl/handshake_const_sink.sv
// Elastic token sink: compares each accepted payload with EXPECTED and, every BATCH
// tokens, emits one report token carrying the saturated mismatch count of that batch.
// Optional macro HANDSHAKE_CONST_SINK_STICKY_ERR_EN adds a sticky 'err' output.
module handshake_const_sink
   import handshake_sink_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter logic [DATA_WIDTH-1:0] EXPECTED    = DATA_WIDTH'(7'h2D),
   parameter int unsigned           BATCH       = 8,
   parameter int unsigned           COUNT_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   handshake_const_sink_if.slave bus
`ifdef HANDSHAKE_CONST_SINK_STICKY_ERR_EN
   ,
   output logic                  err
`endif
);

   localparam int unsigned      TokWidth = clog2_min1(BATCH);
   localparam logic [TokWidth-1:0] TokLast = TokWidth'(BATCH - 1);

   logic                state_d, state_q;
   logic [TokWidth-1:0] tok_d, tok_q;
   logic                armed_q;
   logic                in_fire, out_fire, mismatch;
   logic [COUNT_WIDTH-1:0] mis_cnt;

   // Handshake decode; mismatch only counts on an actual transfer so idle X is ignored.
   always_comb begin
      in_fire  = bus.ins_valid && bus.ins_ready;
      out_fire = bus.outs_valid && bus.outs_ready;
      mismatch = in_fire && (bus.ins != EXPECTED);
   end

   // Batch sequencing: last token of a batch moves to REPORT, report fire returns to ACCEPT.
   always_comb begin
      state_d = state_q;
      tok_d   = tok_q;
      if (state_q == ST_REPORT) begin
         if (out_fire) begin
            state_d = ST_ACCEPT;
            tok_d   = '0;
         end
      end else if (in_fire) begin
         if (tok_q == TokLast) begin
            state_d = ST_REPORT;
            tok_d   = '0;
         end else begin
            tok_d = tok_q + TokWidth'(1);
         end
      end
   end

   // State and token counter; armed_q holds ins_ready low until the first edge after reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_ACCEPT;
         tok_q   <= '0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         tok_q   <= tok_d;
         armed_q <= 1'b1;
      end
   end

   // Mismatch count stays frozen during REPORT, so it doubles as the report payload.
   handshake_sat_counter #(
      .WIDTH (COUNT_WIDTH)
   ) u_mis_cnt (
      .clk (clk),
      .rst (rst),
      .inc (mismatch),
      .clr (out_fire),
      .q   (mis_cnt)
   );

   assign bus.ins_ready  = armed_q && (state_q == ST_ACCEPT);
   assign bus.outs_valid = (state_q == ST_REPORT);
   assign bus.outs       = mis_cnt;

`ifdef HANDSHAKE_CONST_SINK_STICKY_ERR_EN
   logic err_q;

   // Sticky flag: first mismatching transfer sets it, only reset clears it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else if (mismatch) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`endif

endmodule

// File: tb/tb_handshake_const_sink.sv
// Self-checking bench for handshake_const_sink: a default instance and a COUNT_WIDTH=2
// instance share one stimulus stream and are compared each cycle against a token-level model.
module tb_handshake_const_sink;

   localparam int unsigned DW    = 32;
   localparam int unsigned EXP   = 45;
   localparam int unsigned BATCH = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   bit   checking = 1'b0;

   always #5 clk = ~clk;

   handshake_const_sink_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(16)) bus ();
   handshake_const_sink_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(2))  bus_sat ();

   assign bus_sat.ins        = bus.ins;
   assign bus_sat.ins_valid  = bus.ins_valid;
   assign bus_sat.outs_ready = bus.outs_ready;

`ifdef HANDSHAKE_CONST_SINK_STICKY_ERR_EN
   logic err, err_sat;
`endif

   handshake_const_sink #(
      .DATA_WIDTH  (DW),
      .EXPECTED    (32'h2D),
      .BATCH       (BATCH),
      .COUNT_WIDTH (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef HANDSHAKE_CONST_SINK_STICKY_ERR_EN
      ,
      .err (err)
`endif
   );

   handshake_const_sink #(
      .DATA_WIDTH  (DW),
      .EXPECTED    (32'h2D),
      .BATCH       (BATCH),
      .COUNT_WIDTH (2)
   ) dut_sat (
      .clk (clk),
      .rst (rst),
      .bus (bus_sat)
`ifdef HANDSHAKE_CONST_SINK_STICKY_ERR_EN
      ,
      .err (err_sat)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Token-level model: counts tokens and mismatches per batch, report = min(count, max).
   bit m_armed, m_report, m_err;
   int m_tok, m_mis, m_out_full, m_out_sat;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_armed = 0; m_report = 0; m_err = 0;
         m_tok = 0; m_mis = 0; m_out_full = 0; m_out_sat = 0;
      end else begin
         if (m_report) begin
            if (bus.outs_ready) m_report = 0;
         end else if (m_armed && bus.ins_valid) begin
            m_tok++;
            if (bus.ins != EXP) begin
               m_mis++;
               m_err = 1;
            end
            if (m_tok == BATCH) begin
               m_report   = 1;
               m_out_full = (m_mis > 65535) ? 65535 : m_mis;
               m_out_sat  = (m_mis > 3) ? 3 : m_mis;
               m_tok = 0;
               m_mis = 0;
            end
         end
         m_armed = 1;
      end
   end

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (checking) begin
         check("ins_ready", bus.ins_ready, m_armed && !m_report);
         check("outs_valid", bus.outs_valid, m_report);
         if (m_report) check("outs", bus.outs, m_out_full);
         check("sat_ins_ready", bus_sat.ins_ready, m_armed && !m_report);
         check("sat_outs_valid", bus_sat.outs_valid, m_report);
         if (m_report) check("sat_outs", bus_sat.outs, m_out_sat);
`ifdef HANDSHAKE_CONST_SINK_STICKY_ERR_EN
         check("err", err, m_err);
         check("sat_err", err_sat, m_err);
`endif
      end
   end

   // Called at a negedge; presents a token until it is accepted, returns at the next negedge.
   task automatic send_token(input logic [DW-1:0] d);
      int n = 0;
      bus.ins       = d;
      bus.ins_valid = 1'b1;
      while (!bus.ins_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++;
         errors++;
         $display("FAIL send_token: ins_ready stuck low, got 0 required 1 at %0t", $time);
      end
      @(negedge clk);
      bus.ins_valid = 1'b0;
   endtask

   logic [DW-1:0] seq3 [8] = '{45, 0, 45, 7, 45, 45, 1, 45};
   logic [DW-1:0] seq4 [8] = '{45, 1, 45, 45, 45, 45, 45, 2};

   initial begin
      bus.ins = '0;
      bus.ins_valid = 1'b0;
      bus.outs_ready = 1'b0;

      // Reset state and release.
      repeat (3) @(negedge clk);
      check("rst_ins_ready", bus.ins_ready, 0);
      check("rst_outs_valid", bus.outs_valid, 0);
      check("rst_outs", bus.outs, 0);
      checking = 1'b1;
      #2 rst = 1'b1;
      @(negedge clk);
      check("release_ins_ready", bus.ins_ready, 1);

      // Clean batch.
      bus.outs_ready = 1'b1;
      for (int i = 0; i < 8; i++) send_token(32'd45);
      check("clean_outs_valid", bus.outs_valid, 1);
      check("clean_outs", bus.outs, 0);
`ifdef HANDSHAKE_CONST_SINK_STICKY_ERR_EN
      check("clean_err", err, 0);
`endif
      @(negedge clk);
      check("clean_report_done", bus.outs_valid, 0);

      // Three mismatches.
      for (int i = 0; i < 8; i++) send_token(seq3[i]);
      check("mix_outs", bus.outs, 3);
      check("mix_sat_outs", bus_sat.outs, 3);
`ifdef HANDSHAKE_CONST_SINK_STICKY_ERR_EN
      check("mix_err", err, 1);
`endif
      @(negedge clk);

      // Report backpressure with a token waiting.
      bus.outs_ready = 1'b0;
      for (int i = 0; i < 8; i++) send_token(seq4[i]);
      bus.ins = 32'd45;
      bus.ins_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("bp_outs_valid", bus.outs_valid, 1);
         check("bp_outs", bus.outs, 2);
         check("bp_ins_ready", bus.ins_ready, 0);
         @(negedge clk);
      end
      bus.outs_ready = 1'b1;
      send_token(32'd45);
`ifdef HANDSHAKE_CONST_SINK_STICKY_ERR_EN
      check("sticky_err", err, 1);
`endif

      // Reset mid-batch discards the partial batch.
      for (int i = 0; i < 3; i++) send_token(32'd9);
      #2 rst = 1'b0;
      @(negedge clk);
      check("mid_rst_ins_ready", bus.ins_ready, 0);
      check("mid_rst_outs_valid", bus.outs_valid, 0);
`ifdef HANDSHAKE_CONST_SINK_STICKY_ERR_EN
      check("mid_rst_err", err, 0);
`endif
      #2 rst = 1'b1;
      @(negedge clk);
      check("mid_rst_release", bus.ins_ready, 1);

      // All mismatches: full count vs 2-bit saturation.
      for (int i = 0; i < 8; i++) send_token(32'd0);
      check("sat_full_outs", bus.outs, 8);
      check("sat_outs_3", bus_sat.outs, 3);

      // Random traffic with occasional resets.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         bus.ins_valid  = ($urandom_range(0, 99) < 70);
         bus.ins        = ($urandom_range(0, 1) == 1) ? 32'd45 :
                          (($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 63)) : $urandom);
         bus.outs_ready = ($urandom_range(0, 99) < 60);
         if ($urandom_range(0, 399) == 0) begin
            #2 rst = 1'b0;
            @(negedge clk);
            #2 rst = 1'b1;
         end
      end

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
